// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: dcache request/hit handshake, load-data hold, halt-time flush.
// Optional access watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        valid_in,
  input  logic        memRead_in,
  input  logic        memWrite_in,
  input  logic        halt_in,
  input  logic [31:0] aluOut_in,
  input  logic [31:0] dmemstore_in,
  input  logic        ext_stall_in,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  input  logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] dmemaddr_out,
  output logic [31:0] dmemstore_out,
  output logic [31:0] dmemload_out,
  output logic        mem_stall,
  output logic        dflush_req,
  output logic        halt_out,
  output logic        timeout_err
);

  typedef enum logic [2:0] {IDLE, WAIT, HOLD, FLUSH, HALTED} state_t;

  state_t      state, next;
  logic [31:0] held;
  logic        acc, to_hit;

  assign dmemaddr_out  = aluOut_in;
  assign dmemstore_out = dmemstore_in;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          to_err;

  // Fires on the last allowed WAIT cycle; a dhit in that cycle still wins.
  assign to_hit = (state == WAIT) && !dhit && (cnt == CW'(TIMEOUT_CYCLES - 1));
  // A timed-out block stops issuing until reset so the dead access is not retried.
  assign acc = valid_in & (memRead_in | memWrite_in) & ~to_err;
  assign timeout_err = to_err;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt    <= '0;
      to_err <= 1'b0;
    end else begin
      cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
      if (to_hit) to_err <= 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg  = ^TIMEOUT_CYCLES;
  assign to_hit      = 1'b0;
  assign acc         = valid_in & (memRead_in | memWrite_in);
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                        held <= '0;
    else if (state == WAIT && dhit && ext_stall_in) held <= dmemload;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:   if (acc && !dhit)                   next = WAIT;
              else if (valid_in && halt_in && !acc) next = FLUSH;
      WAIT:   if (dhit)        next = ext_stall_in ? HOLD : IDLE;
              else if (to_hit) next = IDLE;
      HOLD:   if (!ext_stall_in) next = IDLE;
      FLUSH:  if (flushed)       next = HALTED;
      HALTED: next = HALTED;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    dREN         = 1'b0;
    dWEN         = 1'b0;
    mem_stall    = 1'b0;
    dflush_req   = 1'b0;
    halt_out     = 1'b0;
    dmemload_out = dmemload;
    case (state)
      IDLE, WAIT: begin
        dREN      = acc & memRead_in;
        dWEN      = acc & memWrite_in & ~memRead_in;
        mem_stall = acc & ~dhit;
      end
      HOLD:   dmemload_out = held;
      FLUSH:  begin dflush_req = 1'b1; mem_stall = 1'b1; end
      HALTED: begin halt_out = 1'b1; mem_stall = 1'b1; end
      default: ;
    endcase
    // Reset drops requests immediately, even while the latch still presents an access.
    if (RST) begin
      dREN       = 1'b0;
      dWEN       = 1'b0;
      mem_stall  = 1'b0;
      dflush_req = 1'b0;
      halt_out   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl; covers the watchdog when MEM_TIMEOUT_EN is defined.
module tb_mem_access_ctrl;
  logic        CLK = 1'b0, RST = 1'b1;
  logic        valid_in, memRead_in, memWrite_in, halt_in, ext_stall_in, dhit, flushed;
  logic [31:0] aluOut_in, dmemstore_in, dmemload;
  logic        dREN, dWEN, mem_stall, dflush_req, halt_out, timeout_err;
  logic [31:0] dmemaddr_out, dmemstore_out, dmemload_out;
  int errors = 0, checks = 0;

  mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .CLK(CLK), .RST(RST), .valid_in(valid_in), .memRead_in(memRead_in),
    .memWrite_in(memWrite_in), .halt_in(halt_in), .aluOut_in(aluOut_in),
    .dmemstore_in(dmemstore_in), .ext_stall_in(ext_stall_in), .dhit(dhit),
    .dmemload(dmemload), .flushed(flushed), .dREN(dREN), .dWEN(dWEN),
    .dmemaddr_out(dmemaddr_out), .dmemstore_out(dmemstore_out),
    .dmemload_out(dmemload_out), .mem_stall(mem_stall), .dflush_req(dflush_req),
    .halt_out(halt_out), .timeout_err(timeout_err));

  always #5 CLK = ~CLK;

  task automatic quiet();
    valid_in = 0; memRead_in = 0; memWrite_in = 0; halt_in = 0; ext_stall_in = 0;
    dhit = 0; flushed = 0; aluOut_in = 0; dmemstore_in = 0; dmemload = 0;
  endtask

  task automatic cyc();
    @(posedge CLK); #1;
  endtask

  task automatic load(input logic [31:0] a, input logic h, input logic [31:0] d);
    valid_in = 1; memRead_in = 1; memWrite_in = 0; aluOut_in = a; dhit = h; dmemload = d;
  endtask

  task automatic test_reset();
    quiet(); RST = 1;
    @(negedge CLK);
    checks++; if (dREN !== 1'b0) begin errors++; $display("FAIL reset dREN: got %b want 0", dREN); end
    checks++; if (dWEN !== 1'b0) begin errors++; $display("FAIL reset dWEN: got %b want 0", dWEN); end
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset mem_stall: got %b want 0", mem_stall); end
    checks++; if (dflush_req !== 1'b0) begin errors++; $display("FAIL reset dflush_req: got %b want 0", dflush_req); end
    checks++; if (halt_out !== 1'b0) begin errors++; $display("FAIL reset halt_out: got %b want 0", halt_out); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset timeout_err: got %b want 0", timeout_err); end
    checks++; if (dmemload_out !== 32'h0) begin errors++; $display("FAIL reset dmemload_out: got %h want 0", dmemload_out); end
    RST = 0;
  endtask

  task automatic test_load_hit();
    int ren_cycles = 0;
    cyc(); load(32'h100, 1, 32'hDEADBEEF);
    @(negedge CLK);
    ren_cycles += int'(dREN);
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL load_hit mem_stall: got %b want 0", mem_stall); end
    checks++; if (dmemload_out !== 32'hDEADBEEF) begin errors++; $display("FAIL load_hit data: got %h want deadbeef", dmemload_out); end
    checks++; if (dmemaddr_out !== 32'h100) begin errors++; $display("FAIL load_hit addr: got %h want 100", dmemaddr_out); end
    checks++; if (dWEN !== 1'b0) begin errors++; $display("FAIL load_hit dWEN: got %b want 0", dWEN); end
    cyc(); quiet();
    @(negedge CLK);
    ren_cycles += int'(dREN);
    checks++; if (ren_cycles != 1) begin errors++; $display("FAIL load_hit dREN cycles: got %0d want 1", ren_cycles); end
  endtask

  task automatic test_store_miss();
    int wen_cycles = 0, stall_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      valid_in = 1; memWrite_in = 1; aluOut_in = 32'h200; dmemstore_in = 32'hCAFEF00D; dhit = (i == 3);
      @(negedge CLK);
      wen_cycles += int'(dWEN); stall_cycles += int'(mem_stall);
      checks++; if (dmemstore_out !== 32'hCAFEF00D) begin errors++; $display("FAIL store data cyc%0d: got %h want cafef00d", i, dmemstore_out); end
      checks++; if (dREN !== 1'b0) begin errors++; $display("FAIL store dREN cyc%0d: got %b want 0", i, dREN); end
    end
    cyc(); quiet();
    @(negedge CLK);
    wen_cycles += int'(dWEN); stall_cycles += int'(mem_stall);
    checks++; if (wen_cycles != 4) begin errors++; $display("FAIL store dWEN cycles: got %0d want 4", wen_cycles); end
    checks++; if (stall_cycles != 3) begin errors++; $display("FAIL store stall cycles: got %0d want 3", stall_cycles); end
  endtask

  task automatic test_hold();
    cyc(); load(32'h300, 0, 32'h0);
    @(negedge CLK);
    checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL hold miss stall: got %b want 1", mem_stall); end
    cyc(); dhit = 1; dmemload = 32'h11112222; ext_stall_in = 1;
    @(negedge CLK);
    checks++; if (dmemload_out !== 32'h11112222) begin errors++; $display("FAIL hold dhit data: got %h want 11112222", dmemload_out); end
    for (int i = 0; i < 3; i++) begin
      cyc(); dhit = 0; dmemload = 32'h33334444; ext_stall_in = (i < 2);
      @(negedge CLK);
      checks++; if (dREN !== 1'b0) begin errors++; $display("FAIL hold reissue cyc%0d: got %b want 0", i, dREN); end
      checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL hold stall cyc%0d: got %b want 0", i, mem_stall); end
      checks++; if (dmemload_out !== 32'h11112222) begin errors++; $display("FAIL hold data cyc%0d: got %h want 11112222", i, dmemload_out); end
    end
    cyc(); quiet(); dmemload = 32'h33334444;
    @(negedge CLK);
    checks++; if (dmemload_out !== 32'h33334444) begin errors++; $display("FAIL hold release data: got %h want 33334444", dmemload_out); end
  endtask

  task automatic test_back_to_back();
    cyc(); load(32'h400, 1, 32'hA5A5A5A5);
    @(negedge CLK);
    checks++; if ({dREN, mem_stall} !== 2'b10) begin errors++; $display("FAIL b2b A ren/stall: got %b want 10", {dREN, mem_stall}); end
    cyc(); load(32'h404, 0, 32'h0);
    @(negedge CLK);
    checks++; if ({dREN, mem_stall} !== 2'b11) begin errors++; $display("FAIL b2b B miss ren/stall: got %b want 11", {dREN, mem_stall}); end
    cyc(); dhit = 1; dmemload = 32'h5A5A5A5A;
    @(negedge CLK);
    checks++; if ({dREN, mem_stall} !== 2'b10) begin errors++; $display("FAIL b2b B hit ren/stall: got %b want 10", {dREN, mem_stall}); end
    checks++; if (dmemload_out !== 32'h5A5A5A5A) begin errors++; $display("FAIL b2b B data: got %h want 5a5a5a5a", dmemload_out); end
    cyc(); quiet();
    @(negedge CLK);
    checks++; if (dREN !== 1'b0) begin errors++; $display("FAIL b2b idle dREN: got %b want 0", dREN); end
  endtask

  task automatic test_rst_mid_wait();
    cyc(); load(32'h500, 0, 32'h0);
    cyc();
    @(negedge CLK);
    checks++; if ({dREN, mem_stall} !== 2'b11) begin errors++; $display("FAIL rst pre wait ren/stall: got %b want 11", {dREN, mem_stall}); end
    #1 RST = 1;
    #1;
    checks++; if ({dREN, dWEN, mem_stall, dflush_req, halt_out} !== 5'b0) begin errors++; $display("FAIL rst async outputs: got %b want 00000", {dREN, dWEN, mem_stall, dflush_req, halt_out}); end
    @(posedge CLK); #1 quiet();
    @(negedge CLK); RST = 0;
    cyc(); load(32'h600, 1, 32'h600D600D);
    @(negedge CLK);
    checks++; if ({dREN, mem_stall} !== 2'b10) begin errors++; $display("FAIL rst after load ren/stall: got %b want 10", {dREN, mem_stall}); end
    checks++; if (dmemload_out !== 32'h600D600D) begin errors++; $display("FAIL rst after load data: got %h want 600d600d", dmemload_out); end
    cyc(); quiet();
  endtask

  task automatic test_halt();
    int flush_cycles = 0;
    cyc(); valid_in = 1; halt_in = 1;
    @(negedge CLK);
    checks++; if (dflush_req !== 1'b0) begin errors++; $display("FAIL halt cyc0 dflush_req: got %b want 0", dflush_req); end
    for (int i = 1; i <= 5; i++) begin
      cyc(); valid_in = 0; halt_in = 0; flushed = (i == 5);
      @(negedge CLK);
      flush_cycles += int'(dflush_req);
      checks++; if ({mem_stall, halt_out} !== 2'b10) begin errors++; $display("FAIL halt flush cyc%0d stall/halt: got %b want 10", i, {mem_stall, halt_out}); end
    end
    checks++; if (flush_cycles != 5) begin errors++; $display("FAIL halt flush cycles: got %0d want 5", flush_cycles); end
    for (int i = 0; i < 3; i++) begin
      cyc(); flushed = 0; load(32'h700, 0, 32'h0);
      @(negedge CLK);
      checks++; if ({halt_out, mem_stall, dflush_req, dREN} !== 4'b1100) begin errors++; $display("FAIL halted cyc%0d halt/stall/flush/ren: got %b want 1100", i, {halt_out, mem_stall, dflush_req, dREN}); end
    end
  endtask

  task automatic test_timeout();
    quiet(); RST = 1;
    @(negedge CLK); RST = 0;
    cyc(); load(32'h800, 0, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      @(negedge CLK);
      checks++; if ({dREN, mem_stall, timeout_err} !== 3'b110) begin errors++; $display("FAIL timeout wait%0d ren/stall/err: got %b want 110", i, {dREN, mem_stall, timeout_err}); end
    end
`ifdef MEM_TIMEOUT_EN
    cyc();
    @(negedge CLK);
    checks++; if ({dREN, mem_stall, timeout_err} !== 3'b001) begin errors++; $display("FAIL timeout fire ren/stall/err: got %b want 001", {dREN, mem_stall, timeout_err}); end
    cyc(); quiet();
    @(negedge CLK);
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout sticky: got %b want 1", timeout_err); end
`else
    for (int i = 0; i < 4; i++) begin
      cyc();
      @(negedge CLK);
      checks++; if ({dREN, mem_stall, timeout_err} !== 3'b110) begin errors++; $display("FAIL no-watchdog wait ren/stall/err: got %b want 110", {dREN, mem_stall, timeout_err}); end
    end
    cyc(); dhit = 1; dmemload = 32'h0BADF00D;
    @(negedge CLK);
    checks++; if (dmemload_out !== 32'h0BADF00D) begin errors++; $display("FAIL no-watchdog late hit data: got %h want 0badf00d", dmemload_out); end
    cyc(); quiet();
`endif
  endtask

  initial begin
    test_reset();
    test_load_hit();
    test_store_miss();
    test_hold();
    test_back_to_back();
    test_rst_mid_wait();
    test_halt();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
